multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a shared-resource multicycle RV32 datapath: one ALU, one unified instruction/data memory port, one register file.
- Decodes the same opcode subset as the single-cycle control path: R-type 51, I-ALU 19, lw 3, sw 35, beq 99.
- Each instruction is spread over 3–5 states, with a ready handshake on the memory port.
- Sits between the instruction register opcode field and the datapath muxes/enables. Also keeps a retired-instruction counter and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, permits a new fetch; sampled only in FETCH.
- opcode, input, 7, instruction register bits [6:0]; valid from DECODE onward.
- zero, input, 1, ALU zero flag.
- mem_ready, input, 1, memory completes the current read/write this cycle.
- pc_write, output, 1, PC load enable.
- ir_write, output, 1, instruction register and old_pc load enable.
- i_or_d, output, 1, memory address select: 0 = PC, 1 = ALUOut.
- mem_read, output, 1, memory read request.
- mem_write, output, 1, memory write request.
- mem_to_reg, output, 1, write-back select: 0 = ALUOut, 1 = MDR.
- reg_write, output, 1, register file write enable.
- alu_src_a, output, 2, ALU A select: 00 = PC, 01 = old_pc, 10 = reg A.
- alu_src_b, output, 2, ALU B select: 00 = reg B, 01 = constant 4, 10 = immediate.
- alu_op, output, 2, ALU op class: 00 = add, 01 = sub/compare, 10 = funct-decoded.
- pc_source, output, 1, PC input select: 0 = ALU result, 1 = ALUOut (branch target).
- instret, output, CNT_W, count of retired instructions.
- illegal, output, 1, sticky illegal-opcode flag.
- fsm_state, output, 4, current state code, for debug.

Behaviour:
- Reset:
  - reset sampled high → next state FETCH, instret = 0, illegal = 0.
  - While reset is high, all control outputs are forced to 0 combinationally, so no PC/IR/memory/register write occurs in a reset cycle.
  - Reset mid-instruction abandons that instruction; it is not counted.
- Default: every control output is 0 unless listed for the current state.
- FETCH:
  - Outputs: mem_read = enable, alu_src_a = 00, alu_src_b = 01, alu_op = 00.
  - With enable & mem_ready: ir_write = 1, pc_write = 1 (pc_source = 0), go to DECODE.
  - Otherwise stay in FETCH, with no writes.
- DECODE:
  - Outputs: alu_src_a = 01, alu_src_b = 10, alu_op = 00 (branch target into ALUOut).
  - Next state by opcode: 51 → EXEC_R; 19 → EXEC_I; 3 or 35 → MEM_ADDR; 99 → BRANCH; any other → ILLEGAL.
- EXEC_R: alu_src_a = 10, alu_src_b = 00, alu_op = 10; go to ALU_WB.
- EXEC_I: alu_src_a = 10, alu_src_b = 10, alu_op = 10; go to ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0; retire; go to FETCH.
- MEM_ADDR: alu_src_a = 10, alu_src_b = 10, alu_op = 00; go to MEM_READ if opcode = 3, else MEM_WRITE.
- MEM_READ: i_or_d = 1, mem_read = 1; hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1; retire; go to FETCH.
- MEM_WRITE: i_or_d = 1, mem_write = 1; hold until mem_ready; retire on the mem_ready cycle; go to FETCH.
- BRANCH:
  - Outputs: alu_src_a = 10, alu_src_b = 00, alu_op = 01, pc_source = 1, pc_write = zero (Mealy on zero).
  - Retire; go to FETCH.
- ILLEGAL: illegal = 1 (sticky); all enables 0; stay until reset; not counted.
- Latency with mem_ready held at 1: R/I = 4 cycles, lw = 5, sw = 4, beq = 3. Each extra low cycle of mem_ready adds 1 cycle.
- Counter arithmetic:
  - instret increments by 1 on the retiring cycle, modulo 2^CNT_W; all-ones wraps to 0.
  - At most one increment per cycle.
- Boundary rules:
  - mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
  - enable is ignored after FETCH, so an in-flight instruction always completes.
  - opcode is sampled only in DECODE and MEM_ADDR; changes elsewhere have no effect.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants OP_R = 7'd51, OP_I = 7'd19, OP_LW = 7'd3, OP_SW = 7'd35, OP_BEQ = 7'd99;
  - ALU op-class codes;
  - alu_src_a / alu_src_b select codes;
  - the 4-bit state encoding, so the datapath and bench decode fsm_state identically.
- One sub-module, retire_counter: CNT_W-bit counter with synchronous reset and an increment enable.
- The FSM stays in multicycle_controller.

Test Plan:
- Reset then enable = 1, mem_ready = 1, opcode = 51 → states FETCH, DECODE, EXEC_R, ALU_WB, FETCH. reg_write high exactly in cycle 4; instret = 1.
- opcode = 3, mem_ready low for 3 cycles in MEM_READ → lw takes 8 cycles; mem_read and i_or_d held high throughout MEM_READ; mem_to_reg = 1 and reg_write = 1 in MEM_WB; instret + 1.
- opcode = 99 with zero = 1, then again with zero = 0 → pc_write = 1 and pc_source = 1 in BRANCH for the first, pc_write = 0 for the second. Both take 3 cycles; instret + 2.
- opcode = 7'd127 → ILLEGAL after DECODE; illegal = 1 and stays; no further pc_write or ir_write for 20 cycles; reset clears it and returns to FETCH.
- Reset asserted in MEM_WRITE with mem_ready = 1 → mem_write = 0 in that cycle; FETCH next cycle; instret unchanged; with enable = 0 the FSM holds in FETCH with mem_read = 0.
- CNT_W = 4, 17 back-to-back sw with mem_ready = 1 → instret reads 15, wraps to 0, ends at 1.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32 control path: opcodes, mux select
// codes and the state encoding seen on fsm_state.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_BEQ = 7'd99;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_REG    = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_I    = 4'd3,
    ST_ALU_WB    = 4'd4,
    ST_MEM_ADDR  = 4'd5,
    ST_MEM_READ  = 4'd6,
    ST_MEM_WB    = 4'd7,
    ST_MEM_WRITE = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_ILLEGAL   = 4'd10
  } state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction/status inputs and mux/enable controls.
interface multicycle_controller_if;
  logic       enable;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_source;

  modport master (
    input  enable, opcode, zero, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );

  modport slave (
    output enable, opcode, zero, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );
endinterface

// File: rtl/multicycle_controller_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM with retire counter and sticky illegal-opcode flag.
//   state     | meaning
//   FETCH     | read instruction at PC, PC += 4 when memory completes
//   DECODE    | branch target into ALUOut, dispatch on opcode
//   EXEC_R/I  | register or immediate ALU operation
//   ALU_WB    | write ALUOut to rd, retire
//   MEM_ADDR  | effective address for lw/sw
//   MEM_READ  | load access, wait for mem_ready
//   MEM_WB    | write MDR to rd, retire
//   MEM_WRITE | store access, retire on mem_ready
//   BRANCH    | compare, take branch on zero, retire
//   ILLEGAL   | unsupported opcode, parked until reset
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_controller_if.master bus,
  output logic [CNT_W-1:0]      instret,
  output logic                  illegal,
  output logic [3:0]            fsm_state
);

  state_t state, next_state;
  logic   retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == ST_ILLEGAL)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state     = state;
    retire         = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_REG;
    bus.alu_op     = ALU_ADD;
    bus.pc_source  = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.mem_read  = bus.enable;
        bus.alu_src_b = SRC_B_FOUR;
        if (bus.enable && bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          next_state   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        bus.alu_src_a = SRC_A_OLD_PC;
        bus.alu_src_b = SRC_B_IMM;
        case (bus.opcode)
          OP_R:         next_state = ST_EXEC_R;
          OP_I:         next_state = ST_EXEC_I;
          OP_LW, OP_SW: next_state = ST_MEM_ADDR;
          OP_BEQ:       next_state = ST_BRANCH;
          default:      next_state = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R: begin
        bus.alu_src_a = SRC_A_REG;
        bus.alu_op    = ALU_FUNCT;
        next_state    = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        bus.alu_src_a = SRC_A_REG;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_op    = ALU_FUNCT;
        next_state    = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        next_state    = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        bus.alu_src_a = SRC_A_REG;
        bus.alu_src_b = SRC_B_IMM;
        next_state    = (bus.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        bus.i_or_d   = 1'b1;
        bus.mem_read = 1'b1;
        if (bus.mem_ready)
          next_state = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
        next_state     = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        bus.i_or_d    = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        bus.alu_src_a = SRC_A_REG;
        bus.alu_op    = ALU_SUB;
        bus.pc_source = 1'b1;
        bus.pc_write  = bus.zero;
        retire        = 1'b1;
        next_state    = ST_FETCH;
      end
      ST_ILLEGAL: next_state = ST_ILLEGAL;
      default:    next_state = ST_FETCH;
    endcase
    // A reset cycle must never write PC, IR, memory or registers.
    if (reset) begin
      retire         = 1'b0;
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src_a  = SRC_A_PC;
      bus.alu_src_b  = SRC_B_REG;
      bus.alu_op     = ALU_ADD;
      bus.pc_source  = 1'b0;
    end
  end

  assign fsm_state = state;

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state and control-word vectors.
module tb_multicycle_controller;
  import rv_ctrl_pkg::*;

  // control word: pw ir iod mr mw m2r rw | asa | asb | aop | ps
  localparam logic [14:0] CW_ZERO  = 15'b0000000_00_00_00_0;
  localparam logic [14:0] CW_FGO   = 15'b1101000_00_01_00_0;
  localparam logic [14:0] CW_FIDLE = 15'b0000000_00_01_00_0;
  localparam logic [14:0] CW_DEC   = 15'b0000000_01_10_00_0;
  localparam logic [14:0] CW_EXR   = 15'b0000000_10_00_10_0;
  localparam logic [14:0] CW_EXI   = 15'b0000000_10_10_10_0;
  localparam logic [14:0] CW_AWB   = 15'b0000001_00_00_00_0;
  localparam logic [14:0] CW_MA    = 15'b0000000_10_10_00_0;
  localparam logic [14:0] CW_MR    = 15'b0011000_00_00_00_0;
  localparam logic [14:0] CW_MWB   = 15'b0000011_00_00_00_0;
  localparam logic [14:0] CW_MW    = 15'b0010100_00_00_00_0;
  localparam logic [14:0] CW_BRT   = 15'b1000000_10_00_01_1;
  localparam logic [14:0] CW_BRN   = 15'b0000000_10_00_01_1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instret;
  logic        illegal;
  logic [3:0]  fsm_state;
  logic [3:0]  instret4;
  logic        illegal4;
  logic [3:0]  fsm_state4;
  int          errors = 0;
  int          checks = 0;

  multicycle_controller_if bus ();
  multicycle_controller_if bus4 ();

  multicycle_controller dut (
    .clk(clk), .reset(reset), .bus(bus),
    .instret(instret), .illegal(illegal), .fsm_state(fsm_state)
  );

  multicycle_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4),
    .instret(instret4), .illegal(illegal4), .fsm_state(fsm_state4)
  );

  wire [14:0] ctl = {bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
                     bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                     bus.alu_op, bus.pc_source};
  wire [14:0] ctl4 = {bus4.pc_write, bus4.ir_write, bus4.i_or_d, bus4.mem_read, bus4.mem_write,
                      bus4.mem_to_reg, bus4.reg_write, bus4.alu_src_a, bus4.alu_src_b,
                      bus4.alu_op, bus4.pc_source};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_R; bus.zero = 1'b1;
    step();
    checks++;
    if (ctl !== CW_ZERO) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CW_ZERO); end
    checks++;
    if (ctl4 !== CW_ZERO) begin errors++; $display("FAIL reset_ctl4: got %b want %b", ctl4, CW_ZERO); end
    checks++;
    if (fsm_state !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_FETCH); end
    checks++;
    if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    reset = 1'b0; bus.enable = 1'b0;
    #1;
    checks++;
    if (ctl !== CW_FIDLE) begin errors++; $display("FAIL reset_idle_ctl: got %b want %b", ctl, CW_FIDLE); end
  endtask

  task automatic test_r_type();
    logic [3:0]  st [4] = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_ALU_WB};
    logic [14:0] cw [4] = '{CW_FGO, CW_DEC, CW_EXR, CW_AWB};
    bus.opcode = OP_R; bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.enable = (i == 0);
      #1;
      checks++;
      if (fsm_state !== st[i]) begin errors++; $display("FAIL r_state c%0d: got %0d want %0d", i, fsm_state, st[i]); end
      checks++;
      if (ctl !== cw[i]) begin errors++; $display("FAIL r_ctl c%0d: got %b want %b", i, ctl, cw[i]); end
      step();
    end
    checks++;
    if (fsm_state !== ST_FETCH) begin errors++; $display("FAIL r_end_state: got %0d want %0d", fsm_state, ST_FETCH); end
    checks++;
    if (instret !== 32'd1) begin errors++; $display("FAIL r_instret: got %0d want 1", instret); end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [8] = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ,
                            ST_MEM_READ, ST_MEM_READ, ST_MEM_READ, ST_MEM_WB};
    logic [14:0] cw [8] = '{CW_FGO, CW_DEC, CW_MA, CW_MR, CW_MR, CW_MR, CW_MR, CW_MWB};
    logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.opcode = OP_LW;
    for (int i = 0; i < 8; i++) begin
      bus.enable = (i == 0);
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (fsm_state !== st[i]) begin errors++; $display("FAIL lw_state c%0d: got %0d want %0d", i, fsm_state, st[i]); end
      checks++;
      if (ctl !== cw[i]) begin errors++; $display("FAIL lw_ctl c%0d: got %b want %b", i, ctl, cw[i]); end
      step();
    end
    checks++;
    if (fsm_state !== ST_FETCH) begin errors++; $display("FAIL lw_end_state: got %0d want %0d", fsm_state, ST_FETCH); end
    checks++;
    if (instret !== 32'd2) begin errors++; $display("FAIL lw_instret: got %0d want 2", instret); end
  endtask

  task automatic test_branch();
    logic [3:0]  st [6] = '{ST_FETCH, ST_DECODE, ST_BRANCH, ST_FETCH, ST_DECODE, ST_BRANCH};
    logic [14:0] cw [6] = '{CW_FGO, CW_DEC, CW_BRT, CW_FGO, CW_DEC, CW_BRN};
    logic        en [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        zr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.opcode = OP_BEQ; bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.enable = en[i];
      bus.zero = zr[i];
      #1;
      checks++;
      if (fsm_state !== st[i]) begin errors++; $display("FAIL beq_state c%0d: got %0d want %0d", i, fsm_state, st[i]); end
      checks++;
      if (ctl !== cw[i]) begin errors++; $display("FAIL beq_ctl c%0d: got %b want %b", i, ctl, cw[i]); end
      step();
    end
    bus.enable = 1'b0;
    checks++;
    if (instret !== 32'd4) begin errors++; $display("FAIL beq_instret: got %0d want 4", instret); end
  endtask

  task automatic test_back_to_back();
    // opcode is garbage outside DECODE/MEM_ADDR to show it is ignored there
    logic [3:0]  st [9] = '{ST_FETCH, ST_DECODE, ST_EXEC_I, ST_ALU_WB, ST_FETCH,
                            ST_DECODE, ST_MEM_ADDR, ST_MEM_WRITE, ST_MEM_WRITE};
    logic [14:0] cw [9] = '{CW_FGO, CW_DEC, CW_EXI, CW_AWB, CW_FGO, CW_DEC, CW_MA, CW_MW, CW_MW};
    logic [6:0]  op [9] = '{7'd0, OP_I, 7'd3, 7'd3, 7'd0, OP_SW, OP_SW, 7'd3, 7'd3};
    logic        en [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        rdy [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      bus.opcode = op[i];
      bus.enable = en[i];
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (fsm_state !== st[i]) begin errors++; $display("FAIL b2b_state c%0d: got %0d want %0d", i, fsm_state, st[i]); end
      checks++;
      if (ctl !== cw[i]) begin errors++; $display("FAIL b2b_ctl c%0d: got %b want %b", i, ctl, cw[i]); end
      step();
    end
    checks++;
    if (fsm_state !== ST_FETCH) begin errors++; $display("FAIL b2b_end_state: got %0d want %0d", fsm_state, ST_FETCH); end
    checks++;
    if (instret !== 32'd6) begin errors++; $display("FAIL b2b_instret: got %0d want 6", instret); end
  endtask

  task automatic test_illegal();
    bus.opcode = 7'd127; bus.enable = 1'b1; bus.mem_ready = 1'b1;
    step();
    bus.enable = 1'b0;
    #1;
    checks++;
    if (fsm_state !== ST_DECODE) begin errors++; $display("FAIL ill_decode: got %0d want %0d", fsm_state, ST_DECODE); end
    step();
    bus.enable = 1'b1; bus.opcode = OP_R;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (fsm_state !== ST_ILLEGAL || illegal !== 1'b1 || ctl !== CW_ZERO)
        begin errors++; $display("FAIL ill_hold c%0d: state %0d illegal %b ctl %b want %0d 1 %b",
                                 i, fsm_state, illegal, ctl, ST_ILLEGAL, CW_ZERO); end
      step();
    end
    checks++;
    if (instret !== 32'd6) begin errors++; $display("FAIL ill_instret: got %0d want 6", instret); end
    bus.enable = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (fsm_state !== ST_FETCH || illegal !== 1'b0 || instret !== 32'd0)
      begin errors++; $display("FAIL ill_clear: state %0d illegal %b instret %0d want 0 0 0",
                               fsm_state, illegal, instret); end
  endtask

  task automatic test_reset_mid();
    bus.opcode = OP_SW; bus.mem_ready = 1'b1; bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (fsm_state !== ST_MEM_WRITE) begin errors++; $display("FAIL rmid_state: got %0d want %0d", fsm_state, ST_MEM_WRITE); end
    checks++;
    if (ctl !== CW_ZERO) begin errors++; $display("FAIL rmid_ctl: got %b want %b", ctl, CW_ZERO); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (fsm_state !== ST_FETCH || ctl !== CW_FIDLE || instret !== 32'd0)
        begin errors++; $display("FAIL rmid_idle c%0d: state %0d ctl %b instret %0d want 0 %b 0",
                                 i, fsm_state, ctl, instret, CW_FIDLE); end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    bus4.opcode = OP_SW; bus4.mem_ready = 1'b1; bus4.enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      repeat (4) step();
      exp = 4'(k);
      checks++;
      if (instret4 !== exp || fsm_state4 !== ST_FETCH)
        begin errors++; $display("FAIL wrap sw%0d: instret %0d state %0d want %0d 0",
                                 k, instret4, fsm_state4, exp); end
    end
    bus4.enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    bus4.enable = 1'b0; bus4.opcode = 7'd0; bus4.zero = 1'b0; bus4.mem_ready = 1'b0;
    step();
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
